req_ack_32bit_receiver: RTL and testbench
=========================================

REQ_ACK_32BIT_RECEIVER -- requirements
Module: req_ack_32bit_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning idle cycles after the last captured word before the frame is closed (range 2..65535).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port request, input, 1, chip-side 4-phase request, asynchronous to clk.
REQ-005 SHALL have port din, input, 32, chip-side data, stable while request=1.
REQ-006 SHALL have port acknowledge, output, 1, 4-phase acknowledge to the chip.
REQ-007 SHALL have ports m_axis_tdata (output, 64), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), the assembled AXI-Stream master.
REQ-008 SHALL have port o_rx_done, output, 1, a one-cycle pulse when a tlast beat is accepted.
REQ-009 SHALL have port o_odd_err, output, 1, sticky flag set when a frame closes with an odd word count.

Function
REQ-010 SHALL pass request through a 2-flop synchroniser (req_s) and SHALL not use raw request in any other logic.
REQ-011 SHALL implement the handshake FSM as IDLE (acknowledge=0) and ACK (acknowledge=1), with acknowledge registered.
- IDLE->ACK when req_s=1 and capacity (REQ-013) holds; din captured on that edge.
- ACK->IDLE when req_s=0.
REQ-012 SHALL place the first word of a pair in tdata[63:32] (half register, half_vld=1) and the second word in tdata[31:0], forming a beat in the pending register (pend_vld=1).
REQ-013 SHALL define capacity as: half_vld=0, or pend_vld=0, or the output slot frees this cycle (m_axis_tvalid=0 or m_axis_tready=1).
REQ-014 SHALL move a pending beat to the output with tlast=0 when a newer beat completes and the output slot is free, so at most one pending beat, one half word and one output beat are ever held.
REQ-015 SHALL count idle cycles in a counter of width clog2(TIMEOUT_CYCLES+1), cleared on every word capture, saturating at TIMEOUT_CYCLES.
REQ-016 SHALL perform a timeout flush when the counter equals TIMEOUT_CYCLES, the output slot is free, and pend_vld=1 or half_vld=1.
- half_vld=0: pending beat goes to the output with tlast=1.
- half_vld=1: any pending beat goes to the output with tlast=0; the half word, zero-padded in [31:0], becomes pending with force_last=1; o_odd_err is set.
REQ-017 SHALL send a pending beat with force_last=1 to the output with tlast=1 on the next free output slot, without waiting for a new timeout.
REQ-018 SHALL give a word capture priority over a timeout flush in the same cycle; the counter clears and no flush occurs.
REQ-019 SHALL hold m_axis_tdata, m_axis_tlast and m_axis_tvalid stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 SHALL assert o_rx_done for exactly one cycle after m_axis_tvalid, m_axis_tready and m_axis_tlast are all 1.
REQ-021 SHALL have a minimum latency of 1 clk from the capture of the second word to the pending register, and SHALL hold that beat until the next beat or the timeout.

Reset
REQ-022 SHALL, while rst=1, immediately clear acknowledge, m_axis_tvalid, m_axis_tlast, m_axis_tdata, o_rx_done, o_odd_err, the synchroniser, half_vld, pend_vld, force_last and the counter, and SHALL set the FSM to IDLE.
REQ-023 SHALL discard any partial frame on reset mid-operation; after release, a still-high request SHALL be acknowledged as a new first word.

Configuration
REQ-024 SHALL, when macro RX_BEAT_CNT_EN is defined, add output o_beat_cnt (32 bits), which counts accepted m_axis beats, wraps at 2^32 and is cleared by reset.
REQ-025 SHALL, when RX_BEAT_CNT_EN is undefined, omit o_beat_cnt and its logic, with all other behaviour identical.

Verification
REQ-026 SHALL verify a four-word frame: words 0xA,0xB,0xC,0xD with tready=1 -> beats 0x0000000A_0000000B (tlast=0), then 0x0000000C_0000000D (tlast=1) TIMEOUT_CYCLES after the last capture, with one o_rx_done pulse.
REQ-027 SHALL verify an odd frame: three words 1,2,3 -> beat 0x1_2 (tlast=0), then 0x00000003_00000000 (tlast=1), with o_odd_err=1.
REQ-028 SHALL verify backpressure: tready=0 for 500 cycles during six words -> acknowledge stalls after REQ-013 fails, no data is lost or reordered, and tdata is stable while stalled.
REQ-029 SHALL verify a simultaneous event: a word captured on the exact cycle the counter reaches TIMEOUT_CYCLES -> no flush occurs and the frame continues.
REQ-030 SHALL verify reset mid-frame: rst pulse after word 1 with request held high -> acknowledge=0 at once, no beat is emitted, and the next capture lands in tdata[63:32].
REQ-031 SHALL verify RX_BEAT_CNT_EN builds: ten beats accepted -> o_beat_cnt=10, and the build without the macro compiles without o_beat_cnt.

Source files
------------

// File: rtl/req_ack_32bit_receiver.sv
// -----------------------------------------------------------------------------
// req_ack_32bit_receiver
//
// Purpose:
//   Receives 32-bit words from a chip over an asynchronous 4-phase
//   request/acknowledge handshake. Consecutive words are paired into 64-bit
//   beats: the first word goes to [63:32] and the second to [31:0]. Beats are
//   presented on an AXI-Stream master. A frame is closed after TIMEOUT_CYCLES
//   idle cycles. A frame with an odd word count is padded with a zero word and
//   flags o_odd_err.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles after the last captured word before the frame
//                   is closed (2..65535)
//
// Ports:
//   clk             single clock
//   rst             asynchronous active-high reset
//   request         chip-side 4-phase request (asynchronous to clk)
//   din[31:0]       chip-side data, stable while request=1
//   acknowledge     registered 4-phase acknowledge to the chip
//   m_axis_tdata    assembled 64-bit beat
//   m_axis_tvalid   beat valid
//   m_axis_tready   downstream ready
//   m_axis_tlast    last beat of the frame
//   o_rx_done       one-cycle pulse after a tlast beat is accepted
//   o_odd_err       sticky flag: a frame closed with an odd word count
//   o_beat_cnt      (only with RX_BEAT_CNT_EN) count of accepted beats, wraps
//
// Build option:
//   RX_BEAT_CNT_EN  when defined, adds the o_beat_cnt output and its counter
// -----------------------------------------------------------------------------
module req_ack_32bit_receiver #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic [31:0] din,
  output logic        acknowledge,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        o_rx_done,
`ifdef RX_BEAT_CNT_EN
  output logic        o_odd_err,
  output logic [31:0] o_beat_cnt
`else
  output logic        o_odd_err
`endif
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             req_meta;
  logic             req_s;
  logic             capture;
  logic             slot_free;
  logic             capacity;
  logic             timeout_hit;

  logic [31:0]      half_word;
  logic             half_vld;
  logic [63:0]      pend_data;
  logic             pend_vld;
  logic             force_last;
  logic [CNT_W-1:0] idle_cnt;

  logic [31:0]      half_word_d;
  logic             half_vld_d;
  logic [63:0]      pend_data_d;
  logic             pend_vld_d;
  logic             force_last_d;
  logic             out_load;
  logic             out_last_d;
  logic             odd_set;

  // Two-flop synchroniser; req_s is the only form of request used below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta <= 1'b0;
      req_s    <= 1'b0;
    end else begin
      req_meta <= request;
      req_s    <= req_meta;
    end
  end

  // A word may only be taken if there is somewhere to put it: a free half
  // slot, a free pending slot, or an output slot that empties this cycle
  // (which lets the pending beat move out to make room).
  always_comb begin
    slot_free = !m_axis_tvalid || m_axis_tready;
    capacity  = !half_vld || !pend_vld || slot_free;
    state_d   = state_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && capacity) begin
          state_d = ACK;
          capture = 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acknowledge <= 1'b0;
    end else begin
      state_q     <= state_d;
      acknowledge <= (state_d == ACK);
    end
  end

  // A capture always wins over a timeout flush in the same cycle.
  assign timeout_hit = (idle_cnt == CNT_MAX) && slot_free &&
                       (pend_vld || half_vld) && !capture;

  // Beat assembly. The output is always loaded from the pending register.
  // A force_last beat leaves first; otherwise the pending beat is pushed out
  // by a newer completed beat or by the timeout. An odd trailing word is
  // zero-padded into the pending slot and goes out as tlast on a later cycle.
  always_comb begin
    half_word_d  = half_word;
    half_vld_d   = half_vld;
    pend_data_d  = pend_data;
    pend_vld_d   = pend_vld;
    force_last_d = force_last;
    out_load     = 1'b0;
    out_last_d   = 1'b0;
    odd_set      = 1'b0;

    if (pend_vld && force_last && slot_free) begin
      out_load     = 1'b1;
      out_last_d   = 1'b1;
      pend_vld_d   = 1'b0;
      force_last_d = 1'b0;
    end else if (capture && half_vld && pend_vld) begin
      out_load   = 1'b1;
      out_last_d = 1'b0;
      pend_vld_d = 1'b0;
    end else if (timeout_hit) begin
      if (pend_vld) begin
        out_load   = 1'b1;
        out_last_d = !half_vld;
        pend_vld_d = 1'b0;
      end
      if (half_vld) begin
        pend_data_d  = {half_word, 32'h0000_0000};
        pend_vld_d   = 1'b1;
        force_last_d = 1'b1;
        half_vld_d   = 1'b0;
        odd_set      = 1'b1;
      end
    end

    if (capture) begin
      if (half_vld) begin
        pend_data_d  = {half_word, din};
        pend_vld_d   = 1'b1;
        force_last_d = 1'b0;
        half_vld_d   = 1'b0;
      end else begin
        half_word_d = din;
        half_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_word  <= '0;
      half_vld   <= 1'b0;
      pend_data  <= '0;
      pend_vld   <= 1'b0;
      force_last <= 1'b0;
    end else begin
      half_word  <= half_word_d;
      half_vld   <= half_vld_d;
      pend_data  <= pend_data_d;
      pend_vld   <= pend_vld_d;
      force_last <= force_last_d;
    end
  end

  // Idle counter: cleared by every capture, saturates at the timeout value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (capture) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Output slot: loads only when free, so a stalled beat never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (out_load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= pend_data;
      m_axis_tlast  <= out_last_d;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rx_done <= 1'b0;
      o_odd_err <= 1'b0;
    end else begin
      o_rx_done <= m_axis_tvalid && m_axis_tready && m_axis_tlast;
      o_odd_err <= o_odd_err || odd_set;
    end
  end

`ifdef RX_BEAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_beat_cnt <= '0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      o_beat_cnt <= o_beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_req_ack_32bit_receiver.sv
// -----------------------------------------------------------------------------
// tb_req_ack_32bit_receiver
//
// Purpose:
//   Self-checking bench for req_ack_32bit_receiver. A chip model drives the
//   4-phase handshake, expected beats are queued as each frame is planned, and
//   a negedge monitor pops and compares them as the DUT hands beats over.
//   With RX_BEAT_CNT_EN defined the beat counter is also checked.
// -----------------------------------------------------------------------------
module tb_req_ack_32bit_receiver;

  localparam int TIMEOUT   = 16;
  localparam int ACK_BOUND = 1000;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        request = 1'b0;
  logic [31:0] din = '0;
  logic        acknowledge;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        o_rx_done;
  logic        o_odd_err;
`ifdef RX_BEAT_CNT_EN
  logic [31:0] o_beat_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cap_cyc = 0;
  int last_fire_cyc = 0;
  int done_pulses = 0;
  int words_sent = 0;

  beat_t       sb[$];
  logic        done_exp = 1'b0;
  logic        stall_hold = 1'b0;
  logic [63:0] held_data = '0;
  logic        held_last = 1'b0;

  req_ack_32bit_receiver #(
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .request      (request),
    .din          (din),
    .acknowledge  (acknowledge),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .o_rx_done    (o_rx_done),
`ifdef RX_BEAT_CNT_EN
    .o_odd_err    (o_odd_err),
    .o_beat_cnt   (o_beat_cnt)
`else
    .o_odd_err    (o_odd_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pops on every accepted beat, stall stability and the
  // one-cycle o_rx_done pulse following each accepted tlast beat.
  always @(negedge clk) begin
    if (rst) begin
      done_exp   = 1'b0;
      stall_hold = 1'b0;
    end else begin
      checks++;
      if (o_rx_done !== done_exp) begin
        errors++;
        $display("[TB] FAIL rx_done: got %b expected %b at cycle %0d", o_rx_done, done_exp, cyc);
      end
      if (o_rx_done === 1'b1) done_pulses++;
      done_exp = 1'b0;

      if (stall_hold) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held_data || m_axis_tlast !== held_last) begin
          errors++;
          $display("[TB] FAIL stall_stable: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_data, held_last);
        end
      end

      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: got d=%h l=%b expected no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          beat_t exp_b;
          exp_b = sb.pop_front();
          if (m_axis_tdata !== exp_b.data || m_axis_tlast !== exp_b.last) begin
            errors++;
            $display("[TB] FAIL beat: got d=%h l=%b expected d=%h l=%b",
                     m_axis_tdata, m_axis_tlast, exp_b.data, exp_b.last);
          end
        end
        done_exp = m_axis_tlast;
        if (m_axis_tlast === 1'b1) last_fire_cyc = cyc;
        stall_hold = 1'b0;
      end else if (m_axis_tvalid === 1'b1) begin
        stall_hold = 1'b1;
        held_data  = m_axis_tdata;
        held_last  = m_axis_tlast;
      end else begin
        stall_hold = 1'b0;
      end
    end
  end

  task automatic push_beat(input logic [63:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic wait_ack(input logic val);
    int n = 0;
    while (acknowledge !== val && n < ACK_BOUND) begin
      @(negedge clk);
      n++;
    end
    if (acknowledge !== val) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack_wait: got acknowledge=%b expected %b within %0d cycles", acknowledge, val, n);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    wait_ack(1'b0);
    @(posedge clk);
    #1;
    din     = w;
    request = 1'b1;
    wait_ack(1'b1);
    last_cap_cyc = cyc;
    @(posedge clk);
    #1;
    request = 1'b0;
    wait_ack(1'b0);
    words_sent++;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || m_axis_tvalid !== 1'b0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || m_axis_tvalid !== 1'b0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d beats pending expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks += 6;
    if (acknowledge !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0", acknowledge); end
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
    if (m_axis_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
    if (m_axis_tdata !== 64'h0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
    if (o_rx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_done: got %b expected 0", o_rx_done); end
    if (o_odd_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_odd_err: got %b expected 0", o_odd_err); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (TIMEOUT + 4) @(negedge clk);
    checks++;
    if (acknowledge !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got ack=%b tvalid=%b expected 0/0", acknowledge, m_axis_tvalid);
    end
  endtask

  task automatic test_four_word();
    int d0;
    int cap_d;
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    d0 = done_pulses;
    push_beat({32'h0000_000A, 32'h0000_000B}, 1'b0);
    push_beat({32'h0000_000C, 32'h0000_000D}, 1'b1);
    send_word(32'h0000_000A);
    send_word(32'h0000_000B);
    send_word(32'h0000_000C);
    send_word(32'h0000_000D);
    cap_d = last_cap_cyc;
    wait_drain(TIMEOUT * 4 + 50);
    checks += 3;
    if (last_fire_cyc - cap_d !== TIMEOUT + 1) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got %0d expected %0d", last_fire_cyc - cap_d, TIMEOUT + 1);
    end
    if (done_pulses - d0 !== 1) begin
      errors++;
      $display("[TB] FAIL rx_done_count: got %0d expected 1", done_pulses - d0);
    end
    if (o_odd_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL even_odd_err: got %b expected 0", o_odd_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[6];
    for (int i = 0; i < 6; i++) w[i] = 32'hB000_0000 + 32'(i * 17 + 3);
    @(posedge clk);
    #1 m_axis_tready = 1'b0;
    words_sent = 0;
    push_beat({w[0], w[1]}, 1'b0);
    push_beat({w[2], w[3]}, 1'b0);
    push_beat({w[4], w[5]}, 1'b1);
    fork
      begin
        for (int i = 0; i < 6; i++) send_word(w[i]);
      end
      begin
        repeat (400) @(negedge clk);
        checks++;
        if (acknowledge !== 1'b0 || request !== 1'b1 || words_sent !== 5) begin
          errors++;
          $display("[TB] FAIL stall: got ack=%b req=%b words=%0d expected 0/1/5", acknowledge, request, words_sent);
        end
        repeat (100) @(negedge clk);
        @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    wait_drain(TIMEOUT * 4 + 50);
  endtask

  task automatic test_simultaneous();
    int c0;
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    push_beat({32'h5150_0001, 32'h5150_0002}, 1'b0);
    push_beat({32'h5150_0003, 32'h5150_0004}, 1'b1);
    send_word(32'h5150_0001);
    send_word(32'h5150_0002);
    c0 = last_cap_cyc;
    while (cyc < c0 + TIMEOUT - 3) @(negedge clk);
    @(posedge clk);
    #1;
    din     = 32'h5150_0003;
    request = 1'b1;
    while (cyc < c0 + TIMEOUT + 1) @(negedge clk);
    checks++;
    if (acknowledge !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simultaneous: got ack=%b tvalid=%b expected 1/0", acknowledge, m_axis_tvalid);
    end
    @(posedge clk);
    #1 request = 1'b0;
    wait_ack(1'b0);
    send_word(32'h5150_0004);
    wait_drain(TIMEOUT * 4 + 50);
  endtask

  task automatic test_odd_frame();
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    push_beat({32'h0000_0001, 32'h0000_0002}, 1'b0);
    push_beat({32'h0000_0003, 32'h0000_0000}, 1'b1);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0003);
    wait_drain(TIMEOUT * 4 + 50);
    checks++;
    if (o_odd_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL odd_err: got %b expected 1", o_odd_err);
    end
    push_beat({32'h0000_0055, 32'h0000_0000}, 1'b1);
    send_word(32'h0000_0055);
    wait_drain(TIMEOUT * 4 + 50);
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    send_word(32'h0000_0011);
    @(posedge clk);
    #1;
    din     = 32'h0000_0022;
    request = 1'b1;
    wait_ack(1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (acknowledge !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ack: got %b expected 0", acknowledge); end
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_tvalid: got %b expected 0", m_axis_tvalid); end
    if (o_odd_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_odd_err: got %b expected 0", o_odd_err); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    push_beat({32'h0000_0022, 32'h0000_0033}, 1'b1);
    wait_ack(1'b1);
    @(posedge clk);
    #1 request = 1'b0;
    wait_ack(1'b0);
    send_word(32'h0000_0033);
    wait_drain(TIMEOUT * 4 + 50);
  endtask

  task automatic test_long_frame();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_beat({32'h1000_0000 + 32'(2 * k), 32'h1000_0000 + 32'(2 * k + 1)}, (k == 9));
    end
    for (int i = 0; i < 20; i++) send_word(32'h1000_0000 + 32'(i));
    wait_drain(TIMEOUT * 4 + 50);
`ifdef RX_BEAT_CNT_EN
    checks++;
    if (o_beat_cnt !== 32'd10) begin
      errors++;
      $display("[TB] FAIL beat_cnt: got %0d expected 10", o_beat_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_four_word();
    test_back_to_back();
    test_simultaneous();
    test_odd_frame();
    test_reset_mid_frame();
    test_long_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
